// File: rtl/modmul_interleaved_if.sv
// Operand/result handshake between the point-arithmetic sequencer and the modular multiplier.
interface modmul_interleaved_if #(
  parameter int WIDTH = 381
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output in_a, in_b, in_m, start,
    input  result, busy, done
  );

  modport slave (
    input  in_a, in_b, in_m, start,
    output result, busy, done
  );
endinterface

// File: rtl/modmul_interleaved.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod m, MSB-first over b,
// one double/add/reduce step per cycle, fixed latency of WIDTH RUN cycles.
module modmul_interleaved #(
  parameter int WIDTH = 381
) (
  input  logic               clk,
  input  logic               reset,
  modmul_interleaved_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  // One iteration: acc_d = (2*acc + b_bit*a) mod m, each step corrected at most once.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   dbl_raw, dbl_red;
  logic [WIDTH:0]   sum_raw, sum_red;
  logic [WIDTH-1:0] acc_d;

  // NOTE: combinational logic uses blocking '=' and assigns every output on every
  // path, so no latch is inferred; registered state below uses '<=' only.
  always_comb begin
    m_ext   = {1'b0, m_q};
    dbl_raw = {acc_q, 1'b0};
    dbl_red = (dbl_raw >= m_ext) ? (dbl_raw - m_ext) : dbl_raw;
    sum_raw = dbl_red + {1'b0, (b_q[cnt_q] ? a_q : '0)};
    sum_red = (sum_raw >= m_ext) ? (sum_raw - m_ext) : sum_raw;
    acc_d   = sum_red[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            m_q     <= bus.in_m;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_modmul_interleaved.sv
// Self-checking bench: a 381-bit and an 8-bit multiplier checked against (a*b)%m arithmetic.
module tb_modmul_interleaved;

  localparam int WB = 381;
  localparam int WS = 8;
  localparam logic [WB-1:0] P381 =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modmul_interleaved_if #(.WIDTH(WB)) big_if ();
  modmul_interleaved_if #(.WIDTH(WS)) small_if ();

  modmul_interleaved #(.WIDTH(WB)) u_big   (.clk(clk), .reset(reset), .bus(big_if.slave));
  modmul_interleaved #(.WIDTH(WS)) u_small (.clk(clk), .reset(reset), .bus(small_if.slave));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WB-1:0] rand381();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r[WB-1:0];
  endfunction

  // Reference: plain double-width product reduced by the modulus.
  function automatic logic [WB-1:0] ref_mulmod(input logic [WB-1:0] a, b, m);
    logic [2*WB-1:0] p;
    p = {{WB{1'b0}}, a} * {{WB{1'b0}}, b};
    p = p % {{WB{1'b0}}, m};
    return p[WB-1:0];
  endfunction

  task automatic drive(input bit sm, input logic [WB-1:0] a, b, m, input logic st);
    if (sm) begin
      small_if.in_a = a[WS-1:0]; small_if.in_b = b[WS-1:0];
      small_if.in_m = m[WS-1:0]; small_if.start = st;
    end else begin
      big_if.in_a = a; big_if.in_b = b; big_if.in_m = m; big_if.start = st;
    end
  endtask

  task automatic sample(input bit sm, output bit bz, output bit dn, output logic [WB-1:0] res);
    if (sm) begin
      bz = small_if.busy; dn = small_if.done; res = {{(WB-WS){1'b0}}, small_if.result};
    end else begin
      bz = big_if.busy; dn = big_if.done; res = big_if.result;
    end
  endtask

  // One op from IDLE; done_lat counts edges from the accepting edge (inclusive) to the done cycle.
  task automatic run_op(input bit sm, input logic [WB-1:0] a, b, m,
                        output logic [WB-1:0] res, output int done_lat,
                        output int busy_n, output int done_n);
    int  w;
    bit  bz, dn;
    w = sm ? WS : WB;
    done_lat = 0; busy_n = 0; done_n = 0; res = '0;
    drive(sm, a, b, m, 1'b1);
    @(negedge clk);
    drive(sm, rand381(), rand381(), rand381(), 1'b0);
    for (int k = 1; k <= 2 * w + 8; k++) begin
      sample(sm, bz, dn, res);
      if (bz) busy_n++;
      if (dn) begin
        done_n++;
        done_lat = k;
      end
      if (!bz) break;
      @(negedge clk);
    end
  endtask

  task automatic op_check(input string tag, input bit sm, input logic [WB-1:0] a, b, m);
    logic [WB-1:0] res;
    int lat, bn, dn, w;
    w = sm ? WS : WB;
    run_op(sm, a, b, m, res, lat, bn, dn);
    check({tag, "_res"}, res, ref_mulmod(a, b, m));
    check({tag, "_lat"}, lat, w + 1);
    check({tag, "_ndone"}, dn, 1);
  endtask

  initial begin
    logic [WB-1:0] res, a, b, m;
    logic [WB-1:0] op_a[3], op_b[3], op_m[3], op_r[3];
    int lat, bn, dn, nd, pp;
    bit bz, dnb;

    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", big_if.busy, 0);
    check("rst_done", big_if.done, 0);
    check("rst_result", big_if.result, 0);
    reset = 1'b0;
    @(negedge clk);

    // Small operands, full-width latency.
    run_op(1'b0, 3, 5, 7, res, lat, bn, dn);
    check("t1_res", res, 1);
    check("t1_lat", lat, WB + 1);
    check("t1_ndone", dn, 1);

    // Zero multiplier; busy spans RUN plus DONE.
    run_op(1'b0, 'h1234, 0, P381, res, lat, bn, dn);
    check("t2_res", res, 0);
    check("t2_busy", bn, WB + 1);

    // Largest operands: (-1)*(-1) = 1 mod p.
    run_op(1'b0, P381 - 1, P381 - 1, P381, res, lat, bn, dn);
    check("t3_max", res, 1);
    check("t3_lat", lat, WB + 1);

    for (int i = 0; i < 24; i++) begin
      m = (i % 2 == 0) ? P381 : (rand381() >> $urandom_range(0, 370));
      if (m < 2) m = 2;
      a = rand381() % m;
      b = rand381() % m;
      op_check("rnd", 1'b0, a, b, m);
    end

    // Precondition violation: result unspecified, timing still fixed.
    run_op(1'b0, 5, 9, 3, res, lat, bn, dn);
    check("viol_lat", lat, WB + 1);
    check("viol_ndone", dn, 1);

    // start held high: latches happen every WIDTH+2 edges, garbage in between is ignored.
    pp = WB + 2;
    for (int j = 0; j < 3; j++) begin
      op_m[j] = P381 - 2 * j;
      op_a[j] = rand381() % op_m[j];
      op_b[j] = rand381() % op_m[j];
      op_r[j] = ref_mulmod(op_a[j], op_b[j], op_m[j]);
    end
    nd = 0;
    for (int c = 0; c < 3 * pp; c++) begin
      if (c % pp == 0) drive(1'b0, op_a[c / pp], op_b[c / pp], op_m[c / pp], 1'b1);
      else             drive(1'b0, rand381(), rand381(), rand381(), 1'b1);
      @(negedge clk);
      sample(1'b0, bz, dnb, res);
      if (dnb) begin
        check("b2b_phase", c % pp, WB);
        check("b2b_res", res, op_r[c / pp]);
        nd++;
      end
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    check("b2b_count", nd, 3);
    @(negedge clk);

    // Reset in the middle of RUN discards the op.
    drive(1'b0, 11, 13, P381, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", big_if.busy, 0);
    check("mid_rst_result", big_if.result, 0);
    nd = 0;
    for (int k = 0; k < WB + 10; k++) begin
      if (big_if.done) nd++;
      @(negedge clk);
    end
    check("mid_rst_nodone", nd, 0);
    op_check("post_rst", 1'b0, 2, 3, 7);

    // Narrow instance.
    run_op(1'b1, 200, 250, 251, res, lat, bn, dn);
    check("w8_res", res, 51);
    check("w8_lat", lat, WS + 1);
    for (int i = 0; i < 30; i++) begin
      m = $urandom_range(2, 255);
      a = $urandom_range(0, int'(m) - 1);
      b = $urandom_range(0, int'(m) - 1);
      op_check("w8_rnd", 1'b1, a, b, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
